// File: rtl/mmc_sector_tx_streamer_if.sv
// Sector transmit bus: start/busy/done control, buffer read port and byte stream to the serializer.
interface mmc_sector_tx_streamer_if;
    logic        iSTART_REQ;
    logic        oBUSY;
    logic [6:0]  oBUF_RD_ADDR;
    logic [31:0] iBUF_RD_DATA;
    logic        oTX_VALID;
    logic [7:0]  oTX_DATA;
    logic        iTX_READY;
    logic        oDONE;

    // Caller side: owns the buffer, the start request and downstream ready.
    modport master (
        output iSTART_REQ, iBUF_RD_DATA, iTX_READY,
        input  oBUSY, oBUF_RD_ADDR, oTX_VALID, oTX_DATA, oDONE
    );

    // Streamer side.
    modport slave (
        input  iSTART_REQ, iBUF_RD_DATA, iTX_READY,
        output oBUSY, oBUF_RD_ADDR, oTX_VALID, oTX_DATA, oDONE
    );
endinterface

// File: rtl/mmc_sector_tx_streamer.sv
// Streams one 512-byte sector from a 128x32 buffer as: start token, data bytes, optional CRC16.
module mmc_sector_tx_streamer #(
    parameter logic [7:0] P_TOKEN   = 8'hFE,
    parameter bit         P_CRC_ENA = 1'b1
) (
    input logic                    iCLOCK,
    input logic                    iRESET_SYNC,
    mmc_sector_tx_streamer_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StToken,
        StData,
        StCrcHi,
        StCrcLo,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  lane_byte;

    // CRC16-CCITT (0x1021), one byte MSB-first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    // Little-endian lane select: byte 0 of each word goes out first.
    always_comb begin
        lane_byte = 8'h00;
        unique case (cnt_q[1:0])
            2'd0: lane_byte = bus.iBUF_RD_DATA[7:0];
            2'd1: lane_byte = bus.iBUF_RD_DATA[15:8];
            2'd2: lane_byte = bus.iBUF_RD_DATA[23:16];
            2'd3: lane_byte = bus.iBUF_RD_DATA[31:24];
            default: lane_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        crc_d            = crc_q;
        bus.oBUSY        = 1'b1;
        bus.oTX_VALID    = 1'b0;
        bus.oTX_DATA     = 8'h00;
        bus.oBUF_RD_ADDR = 7'd0;
        bus.oDONE        = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.oBUSY = 1'b0;
                if (bus.iSTART_REQ) begin
                    state_d = StToken;
                    cnt_d   = 9'd0;
                    crc_d   = 16'h0000;
                end
            end
            StToken: begin
                bus.oTX_VALID = 1'b1;
                bus.oTX_DATA  = P_TOKEN;
                if (bus.iTX_READY) begin
                    state_d = StData;
                end
            end
            StData: begin
                bus.oTX_VALID    = 1'b1;
                bus.oTX_DATA     = lane_byte;
                bus.oBUF_RD_ADDR = cnt_q[8:2];
                if (bus.iTX_READY) begin
                    cnt_d = cnt_q + 9'd1;
                    crc_d = crc16_byte(crc_q, lane_byte);
                    if (cnt_q == 9'd511) begin
                        state_d = P_CRC_ENA ? StCrcHi : StDone;
                    end
                end
            end
            StCrcHi: begin
                bus.oTX_VALID = 1'b1;
                bus.oTX_DATA  = crc_q[15:8];
                if (bus.iTX_READY) begin
                    state_d = StCrcLo;
                end
            end
            StCrcLo: begin
                bus.oTX_VALID = 1'b1;
                bus.oTX_DATA  = crc_q[7:0];
                if (bus.iTX_READY) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                bus.oDONE = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q <= StIdle;
            cnt_q   <= 9'd0;
            crc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
        end
    end

endmodule
